data_sram_slave: RTL and testbench
==================================

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 2, range 0..7, meaning fixed wait cycles per access.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_sram_en  input  1  request valid from core, already exception-gated.
REQ-006 SHALL have port data_sram_wen  input  4  byte write enables; 4'b0000 means read.
REQ-007 SHALL have port data_sram_addr  input  32  byte address.
REQ-008 SHALL have port data_sram_wdata  input  32  write data, byte lanes aligned to wen.
REQ-009 SHALL have port data_sram_rdata  output  32  registered read data.
REQ-010 SHALL have port dataStall  output  1  hold core M stage while high.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-012 SHALL accept a request in IDLE when data_sram_en=1: capture addr, wen, wdata, load wait counter.
REQ-013 SHALL drive dataStall = (IDLE & data_sram_en) | WAIT, combinationally; 0 in RESP.
REQ-014 SHALL transition IDLE->WAIT on accept; WAIT decrements each cycle; WAIT->RESP when counter=0.
REQ-015 SHALL give WAIT_CYC=0 exactly one stall cycle; total stall cycles = load value + 1.
REQ-016 SHALL perform the write (byte lanes per captured wen only) on the WAIT->RESP edge.
REQ-017 SHALL load data_sram_rdata with the word at the captured address on the WAIT->RESP edge for reads; writes leave rdata unchanged.
REQ-018 SHALL return RESP->IDLE unconditionally after one cycle; data_sram_en still high in RESP is not re-accepted.
REQ-019 SHALL accept a new request in the first IDLE cycle after RESP (back-to-back, no bubble beyond RESP).
REQ-020 SHALL index memory by data_sram_addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 ignored (aliasing).
REQ-021 SHALL ignore data_sram_en and input changes while in WAIT or RESP (captured values used).

Reset
REQ-022 SHALL on rst: state=IDLE, counter=0, data_sram_rdata=32'h0, captured registers=0.
REQ-023 SHALL not initialise memory contents on reset.
REQ-024 SHALL drop a pending access on reset mid-operation: no write, rdata=0, dataStall follows REQ-013 from IDLE.

Configuration
REQ-025 SHALL, with DSRAM_RAND_WAIT_EN defined, load the wait counter from a 3-bit LFSR (x^3+x^2+1, reset seed 3'b001, advances once per accepted request) instead of WAIT_CYC.
REQ-026 SHALL, without DSRAM_RAND_WAIT_EN, use WAIT_CYC only; LFSR logic absent.

Structure
REQ-027 SHALL put state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), LFSR seed and default parameter constants in shared package dsram_pkg.
REQ-028 SHALL isolate storage in sub-module dsram_bank (synchronous byte-enable write, synchronous read, 2^ADDR_W x 32).

Verification
REQ-029 Read, WAIT_CYC=2: preload word 0x10 = 32'hDEADBEEF, en=1 wen=0 addr=0x40 -> dataStall high 3 cycles, rdata=32'hDEADBEEF in RESP cycle with dataStall=0.
REQ-030 Partial write: word 0x10 = 32'hDEADBEEF, write wen=4'b0011 wdata=32'h12345678 addr=0x40, then read -> rdata=32'hDEAD5678.
REQ-031 Back-to-back: write then read same address with en held high continuously -> exactly one RESP per request, read returns written data, no duplicate write.
REQ-032 WAIT_CYC=0: read -> dataStall high exactly 1 cycle, RESP the next cycle.
REQ-033 Reset mid-WAIT on write to addr 0x80 -> state IDLE, rdata=0, word 0x20 unchanged on later read.
REQ-034 DSRAM_RAND_WAIT_EN: 8 consecutive reads -> stall lengths follow LFSR sequence 1,2,4,5,7,3,6,1 load values (+1 each), data correct.

Source files
------------

// File: rtl/dsram_pkg.sv
// Shared constants for the data SRAM slave: FSM encoding, wait-LFSR seed/taps
// and default parameter values.
package dsram_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dsramState_e;

    localparam int unsigned DefAddrW   = 10;
    localparam int unsigned DefWaitCyc = 2;

    localparam logic [2:0] LfsrSeed = 3'b001;
    // Galois form of x^3+x^2+1: 1,2,4,5,7,3,6,1,...
    localparam logic [2:0] LfsrTaps = 3'b101;

    function automatic logic [2:0] lfsrNext(input logic [2:0] cur);
        return {cur[1:0], 1'b0} ^ (cur[2] ? LfsrTaps : 3'b000);
    endfunction

endpackage

// File: rtl/dsram_bank.sv
// Data SRAM storage: 2^ADDR_W x 32 words, synchronous byte-enable write and
// synchronous registered read (read register resets to zero, array does not).
module dsram_bank
    import dsram_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [31:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (req) begin
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Only reads update the output word; writes leave it as it was.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (req && (wen == 4'b0000)) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_sram_slave.sv
// Fixed/random-latency data SRAM slave for the core M stage.
// Define DSRAM_RAND_WAIT_EN to draw the wait count from a 3-bit LFSR.
module data_sram_slave
    import dsram_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned WAIT_CYC = DefWaitCyc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        dataStall
);

    dsramState_e       stateQ, stateD;
    logic [2:0]        cntQ, cntD;
    logic [ADDR_W-1:0] addrQ;
    logic [3:0]        wenQ;
    logic [31:0]       wdataQ;
    logic [2:0]        loadVal;
    logic              accept;
    logic              memGo;
    logic              bankReq;
    logic [ADDR_W-1:0] bankAddr;
    logic [3:0]        bankWen;
    logic [31:0]       bankWdata;
    logic              unusedAddr;

    assign unusedAddr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
    assign accept     = (stateQ == StIdle) && data_sram_en;

`ifdef DSRAM_RAND_WAIT_EN
    logic [2:0] lfsrQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsrQ <= LfsrSeed;
        end else if (accept) begin
            lfsrQ <= lfsrNext(lfsrQ);
        end
    end

    assign loadVal = lfsrQ;
`else
    assign loadVal = 3'(WAIT_CYC);
`endif

    // Stall = IDLE accept cycle + loadVal WAIT cycles; a zero load goes straight to RESP.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        memGo  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (data_sram_en) begin
                    if (loadVal == 3'd0) begin
                        stateD = StResp;
                        memGo  = 1'b1;
                    end else begin
                        stateD = StWait;
                        cntD   = loadVal - 3'd1;
                    end
                end
            end
            StWait: begin
                if (cntQ == 3'd0) begin
                    stateD = StResp;
                    memGo  = 1'b1;
                end else begin
                    cntD = cntQ - 3'd1;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            addrQ  <= '0;
            wenQ   <= '0;
            wdataQ <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (accept) begin
                addrQ  <= data_sram_addr[ADDR_W+1:2];
                wenQ   <= data_sram_wen;
                wdataQ <= data_sram_wdata;
            end
        end
    end

    // In IDLE the capture registers are not loaded yet, so use the live request.
    always_comb begin
        if (stateQ == StIdle) begin
            bankAddr  = data_sram_addr[ADDR_W+1:2];
            bankWen   = data_sram_wen;
            bankWdata = data_sram_wdata;
        end else begin
            bankAddr  = addrQ;
            bankWen   = wenQ;
            bankWdata = wdataQ;
        end
    end

    assign bankReq   = memGo & ~rst;
    assign dataStall = accept | (stateQ == StWait);

    dsram_bank #(
        .ADDR_W(ADDR_W)
    ) uBank (
        .clk  (clk),
        .rst  (rst),
        .req  (bankReq),
        .wen  (bankWen),
        .addr (bankAddr),
        .wdata(bankWdata),
        .rdata(data_sram_rdata)
    );

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed self-checking bench for data_sram_slave (WAIT_CYC=2 and WAIT_CYC=0
// instances; LFSR wait sequence when DSRAM_RAND_WAIT_EN is defined).
module tb_data_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en2 = 1'b0;
    logic        en0 = 1'b0;
    logic [3:0]  wen = 4'b0000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata2, rdata0;
    logic        stall2, stall0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_slave #(
        .ADDR_W  (10),
        .WAIT_CYC(2)
    ) uDut2 (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (en2),
        .data_sram_wen  (wen),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata2),
        .dataStall      (stall2)
    );

    data_sram_slave #(
        .ADDR_W  (10),
        .WAIT_CYC(0)
    ) uDut0 (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (en0),
        .data_sram_wen  (wen),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata0),
        .dataStall      (stall0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1 with the selected DUT in IDLE.
    task automatic access(input bit sel, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, output int stalls, output logic [31:0] rd);
        wen   = w;
        addr  = a;
        wdata = d;
        if (sel) en0 = 1'b1;
        else     en2 = 1'b1;
        #1;
        stalls = 0;
        while ((sel ? stall0 : stall2) && stalls < 20) begin
            stalls++;
            @(posedge clk);
            #1;
        end
        rd  = sel ? rdata0 : rdata2;
        en0 = 1'b0;
        en2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int          st;
        logic [31:0] rd;
        logic [7:0]  pat;
        logic [31:0] rdB;

        #3;
        check("reset_rdata", rdata2, 32'h0);
        check("reset_stall_idle", {31'b0, stall2}, 32'h0);
        en2 = 1'b1;
        #1;
        check("reset_stall_en", {31'b0, stall2}, 32'h1);
        en2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef DSRAM_RAND_WAIT_EN
        access(1'b0, 4'hF, 32'h40, 32'hDEADBEEF, st, rd);
        check("wr_stall", st, 32'd3);
        check("wr_keeps_rdata", rd, 32'h0);

        access(1'b0, 4'h0, 32'h40, 32'h0, st, rd);
        check("rd_stall", st, 32'd3);
        check("rd_data", rd, 32'hDEADBEEF);

        access(1'b0, 4'h0, 32'h1043, 32'h0, st, rd);
        check("alias_rd", rd, 32'hDEADBEEF);

        access(1'b0, 4'b0011, 32'h40, 32'h12345678, st, rd);
        check("pwr_keeps_rdata", rd, 32'hDEADBEEF);

        access(1'b0, 4'h0, 32'h40, 32'h0, st, rd);
        check("pwr_merge", rd, 32'hDEAD5678);

        access(1'b0, 4'hF, 32'h80, 32'hA5A50F0F, st, rd);

        // Back-to-back write then read with en held high throughout.
        en2   = 1'b1;
        wen   = 4'hF;
        addr  = 32'h100;
        wdata = 32'hCAFEF00D;
        #1;
        pat = '0;
        rdB = '0;
        for (int i = 0; i < 8; i++) begin
            pat[i] = stall2;
            if (i == 1) wdata = 32'h0BAD0BAD;
            if (i == 3) wen = 4'h0;
            if (i == 7) begin
                rdB = rdata2;
                en2 = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check("b2b_stall_pattern", {24'b0, pat}, 32'h77);
        check("b2b_read", rdB, 32'hCAFEF00D);
        access(1'b0, 4'h0, 32'h100, 32'h0, st, rd);
        check("b2b_reread", rd, 32'hCAFEF00D);

        // Reset in the middle of a write to word 0x20.
        en2   = 1'b1;
        wen   = 4'hF;
        addr  = 32'h80;
        wdata = 32'h11111111;
        @(posedge clk);
        #1;
        check("midwait_stall", {31'b0, stall2}, 32'h1);
        en2 = 1'b0;
        rst = 1'b1;
        #1;
        check("midwait_rst_rdata", rdata2, 32'h0);
        check("midwait_rst_stall", {31'b0, stall2}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(1'b0, 4'h0, 32'h80, 32'h0, st, rd);
        check("midwait_no_write", rd, 32'hA5A50F0F);
        check("post_rst_stall", st, 32'd3);

        access(1'b1, 4'hF, 32'h40, 32'h89ABCDEF, st, rd);
        check("w0_wr_stall", st, 32'd1);
        access(1'b1, 4'h0, 32'h40, 32'h0, st, rd);
        check("w0_rd_stall", st, 32'd1);
        check("w0_rd_data", rd, 32'h89ABCDEF);
`else
        access(1'b0, 4'hF, 32'h40, 32'hDEADBEEF, st, rd);
        check("rand_wr_stall", st, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int expStall;
            case (i)
                0: expStall = 2;
                1: expStall = 3;
                2: expStall = 5;
                3: expStall = 6;
                4: expStall = 8;
                5: expStall = 4;
                6: expStall = 7;
                default: expStall = 2;
            endcase
            access(1'b0, 4'h0, 32'h40, 32'h0, st, rd);
            check($sformatf("rand_stall_%0d", i), st, expStall);
            check($sformatf("rand_data_%0d", i), rd, 32'hDEADBEEF);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
